// File: rtl/vreg_wr_arbiter.sv
// Round-robin arbiter sharing the vector register file write port between the ALU and the load unit.
// Tracks per-register pending writes. Define VREG_WR_ARB_CHECK_EN to add the sticky err output.
module vreg_wr_arbiter #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_dst,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_dst,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              hold,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_dst,
  output logic [NREG-1:0]   busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_dst,
  output logic [DATA_W-1:0] wr_data
`ifdef VREG_WR_ARB_CHECK_EN
  ,
  output logic              err
`endif
);

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LD  = 1'b1
  } grant_e;

  grant_e          last_grant;
  grant_e          last_grant_nxt;
  logic            alu_xfer;
  logic            ld_xfer;
  logic [NREG-1:0] busy_nxt;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    alu_ready      = 1'b0;
    ld_ready       = 1'b0;
    last_grant_nxt = last_grant;
    if (!hold) begin
      // On a tie the requester that did not win last time goes next.
      if (alu_valid && (!ld_valid || last_grant == GNT_LD)) begin
        alu_ready = 1'b1;
      end else if (ld_valid) begin
        ld_ready = 1'b1;
      end
    end
    alu_xfer = alu_valid && alu_ready;
    ld_xfer  = ld_valid && ld_ready;
    if (alu_xfer) begin
      last_grant_nxt = GNT_ALU;
    end else if (ld_xfer) begin
      last_grant_nxt = GNT_LD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      last_grant <= GNT_LD;
    end else begin
      last_grant <= last_grant_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_dst  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= alu_xfer || ld_xfer;
      if (alu_xfer) begin
        wr_dst  <= alu_dst;
        wr_data <= alu_data;
      end else if (ld_xfer) begin
        wr_dst  <= ld_dst;
        wr_data <= ld_data;
      end
    end
  end

  // Clear on the presented write, then apply the reservation so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NREG; i++) begin
      if (wr_en && wr_dst == ADDR_W'(i)) begin
        busy_nxt[i] = 1'b0;
      end
      if (rsv_en && rsv_dst == ADDR_W'(i)) begin
        busy_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

`ifdef VREG_WR_ARB_CHECK_EN
  logic              dbl_rsv;
  logic              unrsv_wr;
  logic [ADDR_W-1:0] xfer_dst;

  always_comb begin
    xfer_dst = alu_xfer ? alu_dst : ld_dst;
    dbl_rsv  = rsv_en && busy[rsv_dst] && !(wr_en && wr_dst == rsv_dst);
    unrsv_wr = (alu_xfer || ld_xfer) && !busy[xfer_dst];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (dbl_rsv || unrsv_wr) begin
      err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!dbl_rsv) else $error("vreg_wr_arbiter: double reservation of v%0d", rsv_dst);
      assert (!unrsv_wr) else $error("vreg_wr_arbiter: write to unreserved v%0d", xfer_dst);
    end
  end
`endif

endmodule

// File: tb/tb_vreg_wr_arbiter.sv
// Bench for vreg_wr_arbiter: per-cycle comparison against a behavioural model plus directed
// checks with hand-computed values.
module tb_vreg_wr_arbiter;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;

  localparam logic [DATA_W-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [DATA_W-1:0] PAT_11 = {32{8'h11}};
  localparam logic [DATA_W-1:0] PAT_22 = {32{8'h22}};
  localparam logic [DATA_W-1:0] PAT_33 = {32{8'h33}};
  localparam logic [DATA_W-1:0] PAT_44 = {32{8'h44}};
  localparam logic [DATA_W-1:0] PAT_55 = {32{8'h55}};

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_dst;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_dst;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              hold;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_dst;
  logic [NREG-1:0]   busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_dst;
  logic [DATA_W-1:0] wr_data;
`ifdef VREG_WR_ARB_CHECK_EN
  logic              err;
`endif

  int checks = 0;
  int errors = 0;

  vreg_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_dst   (alu_dst),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_dst    (ld_dst),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .hold      (hold),
    .rsv_en    (rsv_en),
    .rsv_dst   (rsv_dst),
    .busy      (busy),
    .wr_en     (wr_en),
    .wr_dst    (wr_dst),
    .wr_data   (wr_data)
`ifdef VREG_WR_ARB_CHECK_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who won last, what write is being presented, which registers are pending.
  bit              m_ld_won_last = 1'b1;
  bit              m_wr_en       = 1'b0;
  int              m_wr_dst      = 0;
  logic [DATA_W-1:0] m_wr_data   = '0;
  bit              m_busy [NREG];

  always @(negedge clk or posedge rst) begin : model_cmp
    int          winner;
    logic [NREG-1:0] exp_busy;
    bit          nb [NREG];
    if (rst) begin
      m_ld_won_last = 1'b1;
      m_wr_en       = 1'b0;
      m_wr_dst      = 0;
      m_wr_data     = '0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else begin
      // winner: 0 none, 1 ALU, 2 load
      winner = 0;
      if (!hold) begin
        if (alu_valid && ld_valid) winner = m_ld_won_last ? 1 : 2;
        else if (alu_valid)        winner = 1;
        else if (ld_valid)         winner = 2;
      end
      exp_busy = '0;
      foreach (m_busy[i]) exp_busy[i] = m_busy[i];
      check("model alu_ready", alu_ready, winner == 1);
      check("model ld_ready", ld_ready, winner == 2);
      check("model wr_en", wr_en, m_wr_en);
      check("model wr_dst", wr_dst, m_wr_dst);
      check("model wr_data", wr_data, m_wr_data);
      check("model busy", busy, exp_busy);

      nb = m_busy;
      if (m_wr_en) nb[m_wr_dst] = 1'b0;
      if (rsv_en)  nb[rsv_dst]  = 1'b1;
      m_busy = nb;

      m_wr_en = (winner != 0);
      if (winner == 1) begin
        m_ld_won_last = 1'b0;
        m_wr_dst      = alu_dst;
        m_wr_data     = alu_data;
      end else if (winner == 2) begin
        m_ld_won_last = 1'b1;
        m_wr_dst      = ld_dst;
        m_wr_data     = ld_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    alu_dst   = '0;
    alu_data  = '0;
    ld_valid  = 1'b0;
    ld_dst    = '0;
    ld_data   = '0;
    hold      = 1'b0;
    rsv_en    = 1'b0;
    rsv_dst   = '0;
  endtask

  task automatic do_reset();
    step();
    idle_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset wr_en", wr_en, 1'b0);
    check("reset wr_dst", wr_dst, 3'd0);
    check("reset wr_data", wr_data, '0);
    check("reset busy", busy, 8'h00);
    rst = 1'b0;

    // Single ALU request
    alu_valid = 1'b1; alu_dst = 3'd3; alu_data = PAT_A5;
    @(negedge clk);
    check("single alu_ready", alu_ready, 1'b1);
    check("single ld_ready", ld_ready, 1'b0);
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    check("single wr_en", wr_en, 1'b1);
    check("single wr_dst", wr_dst, 3'd3);
    check("single wr_data", wr_data, PAT_A5);
    step();
    @(negedge clk);
    check("single wr_en drop", wr_en, 1'b0);

    // Both valid continuously from reset: ALU, LD, ALU, LD
    do_reset();
    alu_valid = 1'b1; alu_dst = 3'd1; alu_data = PAT_11;
    ld_valid  = 1'b1; ld_dst  = 3'd2; ld_data  = PAT_22;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr alu_ready", alu_ready, (k % 2) == 0);
      check("rr ld_ready", ld_ready, (k % 2) == 1);
      if (k > 0) begin
        check("rr wr_en", wr_en, 1'b1);
        check("rr wr_dst", wr_dst, (k % 2 == 1) ? 3'd1 : 3'd2);
      end
      step();
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    check("rr last wr_en", wr_en, 1'b1);
    check("rr last wr_dst", wr_dst, 3'd2);
    check("rr last wr_data", wr_data, PAT_22);

    // Reserve v5, then the load unit writes it
    step();
    rsv_en = 1'b1; rsv_dst = 3'd5;
    step();
    rsv_en = 1'b0;
    @(negedge clk);
    check("rsv busy set", busy, 8'h20);
    step();
    ld_valid = 1'b1; ld_dst = 3'd5; ld_data = PAT_33;
    @(negedge clk);
    check("ld5 ld_ready", ld_ready, 1'b1);
    step();
    ld_valid = 1'b0;
    @(negedge clk);
    check("ld5 wr_en", wr_en, 1'b1);
    check("ld5 busy still set", busy, 8'h20);
    step();
    @(negedge clk);
    check("ld5 busy cleared", busy, 8'h00);

    // New reservation of v5 in the same cycle its write is presented survives
    step();
    rsv_en = 1'b1; rsv_dst = 3'd5;
    step();
    rsv_en = 1'b0;
    ld_valid = 1'b1; ld_dst = 3'd5; ld_data = PAT_33;
    step();
    ld_valid = 1'b0;
    rsv_en = 1'b1; rsv_dst = 3'd5;
    @(negedge clk);
    check("setclr wr_en", wr_en, 1'b1);
    check("setclr wr_dst", wr_dst, 3'd5);
    step();
    rsv_en = 1'b0;
    @(negedge clk);
    check("setclr busy kept", busy, 8'h20);

    // hold blocks both requesters; ALU wins first after release
    do_reset();
    rsv_en = 1'b1; rsv_dst = 3'd2;
    step();
    rsv_dst = 3'd3;
    step();
    rsv_en = 1'b0;
    hold = 1'b1;
    alu_valid = 1'b1; alu_dst = 3'd1; alu_data = PAT_44;
    ld_valid  = 1'b1; ld_dst  = 3'd6; ld_data  = PAT_55;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold alu_ready", alu_ready, 1'b0);
      check("hold ld_ready", ld_ready, 1'b0);
      check("hold wr_en", wr_en, 1'b0);
      step();
    end
    hold = 1'b0;
    @(negedge clk);
    check("release alu_ready", alu_ready, 1'b1);
    check("release ld_ready", ld_ready, 1'b0);
    check("release busy", busy, 8'h0C);

    // Async reset while a write is presented
    step();
    alu_valid = 1'b0; ld_valid = 1'b0;
    #1;
    check("pre-rst wr_en", wr_en, 1'b1);
    check("pre-rst busy", busy, 8'h0C);
    rst = 1'b1;
    #1;
    check("async rst wr_en", wr_en, 1'b0);
    check("async rst busy", busy, 8'h00);
    check("async rst wr_dst", wr_dst, 3'd0);
    #1;
    rst = 1'b0;

    // After reset the grant history restarts: a lone load request goes straight through
    step();
    ld_valid = 1'b1; ld_dst = 3'd4; ld_data = PAT_55;
    @(negedge clk);
    check("post-rst ld_ready", ld_ready, 1'b1);
    step();
    ld_valid = 1'b0;
    @(negedge clk);
    check("post-rst wr_dst", wr_dst, 3'd4);
    check("post-rst wr_data", wr_data, PAT_55);

`ifdef VREG_WR_ARB_CHECK_EN
    do_reset();
    @(negedge clk);
    check("err reset", err, 1'b0);
    step();
    rsv_en = 1'b1; rsv_dst = 3'd2;
    step();
    step();
    rsv_en = 1'b0;
    @(negedge clk);
    check("err double rsv", err, 1'b1);
    step();
    step();
    @(negedge clk);
    check("err sticky", err, 1'b1);
    do_reset();
    @(negedge clk);
    check("err cleared by rst", err, 1'b0);
`endif

    step();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
